// File: rtl/shift_sequencer.sv
// Purpose: command-driven controller for an 8-bit universal shift register (load / N-step shift / hold).
// Latency: accept-to-done is 3 edges for LOAD, N+2 edges for an N-step shift, 2 edges for HOLD or a zero-step shift.
// Backpressure: cmd_ready is high only in IDLE; cmd_* is ignored while busy, abort is honoured only in SHIFT.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake; cmd_op 00 HOLD, 01 SHR, 10 SHL, 11 LOAD
//   cmd_amt, cmd_data, cmd_fill shift step count, load value, serial fill bit
//   abort                      ends a shift sequence after the current step
//   busy, done, done_aborted   status; done is a one-cycle pulse qualified by done_aborted
//   result                     register value captured at completion, held until the next completion
//   sr_c1/sr_c0/sr_enb/sr_sli/sr_sri/sr_in  register control pins; sr_out is the register readback
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_fill,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             done_aborted,
  output logic [WIDTH-1:0] result,
  output logic             sr_c1,
  output logic             sr_c0,
  output logic             sr_enb,
  output logic             sr_sli,
  output logic             sr_sri,
  output logic [WIDTH-1:0] sr_in,
  input  logic [WIDTH-1:0] sr_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0]       OP_SHR  = 2'b01;
  localparam logic [1:0]       OP_SHL  = 2'b10;
  localparam logic [1:0]       OP_LOAD = 2'b11;
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO    = '0;

  state_t           state_q, state_d;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] rem_q;
  logic [WIDTH-1:0] data_q;
  logic             fill_q;
  logic             aborted_q;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_op == OP_LOAD)
            state_d = LOAD;
          else if ((cmd_op == OP_SHR || cmd_op == OP_SHL) && cmd_amt != ZERO)
            state_d = SHIFT;
          else
            state_d = DONE;
        end
      end
      LOAD:  state_d = DONE;
      // The step taken on the abort edge still happens; we just stop after it.
      SHIFT: if (rem_q == ONE || abort) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= 2'b00;
      rem_q        <= ZERO;
      data_q       <= '0;
      fill_q       <= 1'b0;
      aborted_q    <= 1'b0;
      result       <= '0;
      done         <= 1'b0;
      done_aborted <= 1'b0;
    end else begin
      state_q      <= state_d;
      done         <= 1'b0;
      done_aborted <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            rem_q     <= cmd_amt;
            data_q    <= cmd_data;
            fill_q    <= cmd_fill;
            aborted_q <= 1'b0;
          end
        end
        SHIFT: begin
          rem_q <= rem_q - ONE;
          // Aborting on the final step is a normal completion, not an abort.
          if (abort && rem_q > ONE) aborted_q <= 1'b1;
        end
        DONE: begin
          result       <= sr_out;
          done         <= 1'b1;
          done_aborted <= aborted_q;
        end
        default: ;
      endcase
    end
  end

  // Moore outputs. sr_in defaults to sr_out so shifts chain on the register's own value.
  always_comb begin
    sr_enb = 1'b0;
    sr_c1  = 1'b0;
    sr_c0  = 1'b0;
    sr_sli = 1'b0;
    sr_sri = 1'b0;
    sr_in  = sr_out;
    case (state_q)
      LOAD: begin
        sr_enb = 1'b1;
        sr_c1  = 1'b1;
        sr_c0  = 1'b1;
        sr_in  = data_q;
      end
      SHIFT: begin
        sr_enb = 1'b1;
        sr_c1  = op_q[1];
        sr_c0  = op_q[0];
        sr_sli = fill_q;
        sr_sri = fill_q;
      end
      default: ;
    endcase
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: drives commands against a behavioural 8-bit universal shift register
// and compares results, pin activity and latency with a reference computed from the command rules.
module tb_shift_sequencer;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_amt;
  logic [7:0] cmd_data;
  logic       cmd_fill;
  logic       abort;
  logic       busy;
  logic       done;
  logic       done_aborted;
  logic [7:0] result;
  logic       sr_c1, sr_c0, sr_enb, sr_sli, sr_sri;
  logic [7:0] sr_in;
  logic [7:0] sr_out;

  shift_sequencer #(.WIDTH(8), .CNT_W(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_amt      (cmd_amt),
    .cmd_data     (cmd_data),
    .cmd_fill     (cmd_fill),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .done_aborted (done_aborted),
    .result       (result),
    .sr_c1        (sr_c1),
    .sr_c0        (sr_c0),
    .sr_enb       (sr_enb),
    .sr_sli       (sr_sli),
    .sr_sri       (sr_sri),
    .sr_in        (sr_in),
    .sr_out       (sr_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // The external universal shift register being controlled.
  logic [7:0] sr_reg = 8'h00;
  always @(posedge clk) begin
    if (sr_enb) begin
      case ({sr_c1, sr_c0})
        2'b01:   sr_reg <= {sr_sri, sr_reg[7:1]};
        2'b10:   sr_reg <= {sr_reg[6:0], sr_sli};
        2'b11:   sr_reg <= sr_in;
        default: sr_reg <= sr_reg;
      endcase
    end
  end
  assign sr_out = sr_reg;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] exp_reg = 8'h00;  // reference view of the register contents

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_shr(input logic [7:0] v, input logic f);
    return 8'((int'(v) / 2) + (f ? 128 : 0));
  endfunction

  function automatic logic [7:0] ref_shl(input logic [7:0] v, input logic f);
    return 8'(((int'(v) * 2) % 256) + (f ? 1 : 0));
  endfunction

  // Issue one command (assumes controller is idle, sampled 1 time unit after an edge) and
  // follow it to done. abort_at=k raises abort during the k-th shift cycle (0 = never).
  task automatic do_cmd(input string name, input logic [1:0] op, input int amt,
                        input logic [7:0] data, input logic fill, input int abort_at,
                        input bit noise);
    int         exp_enb, exp_lat, edges, enb_seen, shift_idx;
    bit         exp_ab;
    logic [7:0] exp_res;
    exp_ab  = 1'b0;
    exp_res = exp_reg;
    exp_enb = 0;
    exp_lat = 2;
    if (op == 2'b11) begin
      exp_res = data;
      exp_enb = 1;
      exp_lat = 3;
    end else if (op == 2'b01 || op == 2'b10) begin
      exp_enb = amt;
      if (abort_at > 0 && abort_at < amt) begin
        exp_enb = abort_at;
        exp_ab  = 1'b1;
      end
      for (int i = 0; i < exp_enb; i++)
        exp_res = (op == 2'b01) ? ref_shr(exp_res, fill) : ref_shl(exp_res, fill);
      exp_lat = exp_enb + 2;
    end

    check({name, " cmd_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_amt   = 3'(amt);
    cmd_data  = data;
    cmd_fill  = fill;
    @(posedge clk); #1;
    edges     = 1;
    enb_seen  = 0;
    shift_idx = 0;
    cmd_valid = 1'b0;
    while (!done && edges < 24) begin
      cmd_op    = 2'($urandom);
      cmd_amt   = 3'($urandom);
      cmd_data  = 8'($urandom);
      cmd_fill  = 1'($urandom);
      cmd_valid = (noise && busy) ? 1'($urandom) : 1'b0;
      abort     = noise ? 1'($urandom) : 1'b0;  // must be ignored outside SHIFT
      if (sr_enb) begin
        enb_seen++;
        if (op == 2'b11) begin
          check({name, " load mode"}, {sr_c1, sr_c0}, 2'b11);
          check({name, " load sr_in"}, sr_in, data);
        end else begin
          shift_idx++;
          abort = (shift_idx == abort_at);
          check({name, " shift mode"}, {sr_c1, sr_c0}, op);
          check({name, " shift fill"}, {sr_sli, sr_sri}, {fill, fill});
          check({name, " shift sr_in"}, sr_in, sr_out);
        end
      end
      @(posedge clk); #1;
      edges++;
    end
    cmd_valid = 1'b0;
    abort     = 1'b0;
    check({name, " done seen"}, done, 1);
    check({name, " latency"}, edges, exp_lat);
    check({name, " result"}, result, exp_res);
    check({name, " done_aborted"}, done_aborted, exp_ab);
    check({name, " enb cycles"}, enb_seen, exp_enb);
    check({name, " busy after done"}, busy, 0);
    check({name, " register"}, sr_out, exp_res);
    exp_reg = exp_res;
  endtask

  task automatic idle_check(input string name);
    @(posedge clk); #1;
    check({name, " done cleared"}, done, 0);
    check({name, " result held"}, result, exp_reg);
    check({name, " no enb idle"}, sr_enb, 0);
  endtask

  initial begin
    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_amt   = 3'd0;
    cmd_data  = 8'h00;
    cmd_fill  = 1'b0;
    abort     = 1'b0;
    #2 rst_n = 1'b0;
    #10;
    check("reset cmd_ready", cmd_ready, 1);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset result", result, 0);
    check("reset pins", {sr_enb, sr_c1, sr_c0, sr_sli, sr_sri}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a shift sequence
    do_cmd("pre-load", 2'b11, 0, 8'h5A, 1'b0, 0, 1'b0);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_amt = 3'd7; cmd_fill = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("mid-shift enb", sr_enb, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    exp_reg = ref_shr(ref_shr(8'h5A, 1'b1), 1'b1);
    rst_n = 1'b0;
    #1;
    check("async reset busy", busy, 0);
    check("async reset cmd_ready", cmd_ready, 1);
    check("async reset enb", sr_enb, 0);
    check("async reset mode", {sr_c1, sr_c0, sr_sli, sr_sri}, 0);
    check("async reset done", done, 0);
    check("async reset result", result, 0);
    check("register kept", sr_out, exp_reg);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("post-reset no enb", sr_enb, 0);
      check("post-reset no done", done, 0);
    end

    // Directed cases
    do_cmd("load 54", 2'b11, 0, 8'h54, 1'b0, 0, 1'b0);
    check("load 54 const", result, 8'h54);
    idle_check("load 54");
    do_cmd("shr3", 2'b01, 3, 8'h00, 1'b1, 0, 1'b0);
    check("shr3 const", result, 8'hEA);
    idle_check("shr3");
    do_cmd("load ff", 2'b11, 0, 8'hFF, 1'b0, 0, 1'b0);
    do_cmd("shl7 noisy", 2'b10, 7, 8'h00, 1'b0, 0, 1'b1);
    check("shl7 const", result, 8'h80);
    idle_check("shl7");
    do_cmd("shr5 abort", 2'b01, 5, 8'h00, 1'b0, 2, 1'b0);
    check("shr5 abort const", result, 8'h20);
    check("shr5 aborted const", done_aborted, 1);
    idle_check("shr5 abort");
    do_cmd("hold", 2'b00, 6, 8'h3C, 1'b1, 0, 1'b0);
    do_cmd("shl0 b2b", 2'b10, 0, 8'h00, 1'b1, 0, 1'b0);
    idle_check("shl0");
    do_cmd("shr abort last", 2'b01, 3, 8'h00, 1'b1, 3, 1'b0);

    // Random commands, sometimes back-to-back
    for (int n = 0; n < 40; n++) begin
      logic [1:0] r_op;
      int         r_amt, r_ab;
      r_op  = 2'($urandom);
      r_amt = int'($urandom_range(0, 7));
      r_ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0;
      do_cmd("random", r_op, r_amt, 8'($urandom), 1'($urandom), r_ab, 1'($urandom));
      if ($urandom_range(0, 1) == 1) idle_check("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
